// File: rtl/rd_8_3_seq_if.sv
// Handshake and status bundle between a row-status source, the sequential
// row encoder and the downstream 3-to-8 row decoder.
interface rd_8_3_seq_if;
  logic [7:0] rows_in;
  logic       load;
  logic       out_ready;
  logic       C;
  logic       D;
  logic       E;
  logic       en_out;
  logic       busy;
  logic [3:0] remaining;
  logic       done;
  logic       load_err;

  modport master (
    output rows_in, load, out_ready,
    input  C, D, E, en_out, busy, remaining, done, load_err
  );

  modport slave (
    input  rows_in, load, out_ready,
    output C, D, E, en_out, busy, remaining, done, load_err
  );
endinterface

// File: rtl/rd_8_3_seq.sv
// Sequential row encoder: captures a multi-hot row vector and issues one
// 3-bit row address per handshake, lowest-first or highest-first.
module rd_8_3_seq #(
  parameter bit DESCEND = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  rd_8_3_seq_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0] state_reg,   state_next;
  logic [7:0] pending_reg, pending_next;
  logic [2:0] addr_reg,    addr_next;
  logic       en_reg,      en_next;
  logic [3:0] rem_reg,     rem_next;
  logic       done_reg,    done_next;
  logic       lerr_reg,    lerr_next;

  logic [7:0] addr_mask;
  logic [7:0] cleared;
  logic       handshake;

  // Later loop iterations win, so the loop direction sets the priority.
  function automatic logic [2:0] first_row(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (DESCEND) begin
        if (v[i]) idx = 3'(i);
      end else begin
        if (v[7-i]) idx = 3'(7 - i);
      end
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign addr_mask[gi] = (addr_reg == 3'(gi));
    end
  endgenerate

  assign cleared   = pending_reg & ~addr_mask;
  assign handshake = (state_reg == SCAN) && en_reg && bus.out_ready;

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    addr_next    = addr_reg;
    en_next      = en_reg;
    rem_next     = rem_reg;
    done_next    = 1'b0;
    lerr_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          if (bus.rows_in != 8'h00) begin
            state_next   = SCAN;
            pending_next = bus.rows_in;
            addr_next    = first_row(bus.rows_in);
            en_next      = 1'b1;
            rem_next     = popcount(bus.rows_in);
          end else begin
            done_next    = 1'b1;
          end
        end
      end
      SCAN: begin
        // A load that coincides with the final handshake is still rejected.
        if (bus.load) lerr_next = 1'b1;
        if (handshake) begin
          pending_next = cleared;
          if (cleared != 8'h00) begin
            addr_next = first_row(cleared);
            rem_next  = rem_reg - 4'd1;
          end else begin
            state_next = IDLE;
            en_next    = 1'b0;
            rem_next   = 4'd0;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        en_next    = 1'b0;
        rem_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= 8'h00;
      addr_reg    <= 3'd0;
      en_reg      <= 1'b0;
      rem_reg     <= 4'd0;
      done_reg    <= 1'b0;
      lerr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      addr_reg    <= addr_next;
      en_reg      <= en_next;
      rem_reg     <= rem_next;
      done_reg    <= done_next;
      lerr_reg    <= lerr_next;
    end
  end

  assign bus.C         = addr_reg[2];
  assign bus.D         = addr_reg[1];
  assign bus.E         = addr_reg[0];
  assign bus.en_out    = en_reg;
  assign bus.busy      = (state_reg == SCAN);
  assign bus.remaining = rem_reg;
  assign bus.done      = done_reg;
  assign bus.load_err  = lerr_reg;

endmodule

// File: tb/tb_rd_8_3_seq.sv
// Drives ascending and descending encoders side by side; a queue per DUT holds
// the expected address order and is drained on every handshake.
module tb_rd_8_3_seq;
  logic       clk;
  logic       rst_n;
  logic [7:0] rows_in;
  logic       load;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  logic [2:0] q0[$];
  logic [2:0] q1[$];

  rd_8_3_seq_if if0();
  rd_8_3_seq_if if1();

  assign if0.rows_in   = rows_in;
  assign if0.load      = load;
  assign if0.out_ready = out_ready;
  assign if1.rows_in   = rows_in;
  assign if1.load      = load;
  assign if1.out_ready = out_ready;

  rd_8_3_seq #(.DESCEND(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  rd_8_3_seq #(.DESCEND(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] st(input logic en, input logic bsy, input logic [3:0] rem,
                                    input logic dn, input logic le);
    return {en, bsy, rem, dn, le};
  endfunction

  function automatic logic [7:0] st0();
    return {if0.en_out, if0.busy, if0.remaining, if0.done, if0.load_err};
  endfunction

  function automatic logic [7:0] st1();
    return {if1.en_out, if1.busy, if1.remaining, if1.done, if1.load_err};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Status vector is {en_out, busy, remaining[3:0], done, load_err}.
  task automatic chk_st(input string tag, input logic [7:0] exp);
    chk({tag, "_st_d0"}, st0(), exp);
    chk({tag, "_st_d1"}, st1(), exp);
  endtask

  task automatic chk_addr(input string tag, input logic [2:0] exp0, input logic [2:0] exp1);
    chk({tag, "_addr_d0"}, {5'b0, if0.C, if0.D, if0.E}, {5'b0, exp0});
    chk({tag, "_addr_d1"}, {5'b0, if1.C, if1.D, if1.E}, {5'b0, exp1});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_q_d0"}, 8'(q0.size()), 8'd0);
    chk({tag, "_q_d1"}, 8'(q1.size()), 8'd0);
  endtask

  task automatic push_exp(input logic [7:0] v);
    for (int i = 0; i < 8; i++)  if (v[i]) q0.push_back(3'(i));
    for (int i = 7; i >= 0; i--) if (v[i]) q1.push_back(3'(i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a handshake happens at the next rising edge when both are high.
  always @(negedge clk) begin
    logic [2:0] ea;
    logic [3:0] er;
    if (rst_n && if0.en_out && out_ready) begin
      checks++;
      assert (q0.size() > 0) else begin
        errors++;
        $error("FAIL hs_spurious_d0 observed addr=%0d expected=no handshake", {if0.C, if0.D, if0.E});
      end
      if (q0.size() > 0) begin
        er = 4'(q0.size());
        ea = q0.pop_front();
        chk("hs_addr_d0", {5'b0, if0.C, if0.D, if0.E}, {5'b0, ea});
        chk("hs_rem_d0", {4'b0, if0.remaining}, {4'b0, er});
        $display("hs d0 addr=%0d remaining=%0d", {if0.C, if0.D, if0.E}, if0.remaining);
      end
    end
    if (rst_n && if1.en_out && out_ready) begin
      checks++;
      assert (q1.size() > 0) else begin
        errors++;
        $error("FAIL hs_spurious_d1 observed addr=%0d expected=no handshake", {if1.C, if1.D, if1.E});
      end
      if (q1.size() > 0) begin
        er = 4'(q1.size());
        ea = q1.pop_front();
        chk("hs_addr_d1", {5'b0, if1.C, if1.D, if1.E}, {5'b0, ea});
        chk("hs_rem_d1", {4'b0, if1.remaining}, {4'b0, er});
        $display("hs d1 addr=%0d remaining=%0d", {if1.C, if1.D, if1.E}, if1.remaining);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=still running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; rows_in = 8'h00; out_ready = 1'b0;
    step(); step();
    chk_st("reset", st(0, 0, 4'd0, 0, 0));
    chk_addr("reset", 3'd0, 3'd0);
    rst_n = 1'b1;
    step();

    // Multi-hot vector with continuous ready: one address per cycle.
    out_ready = 1'b1;
    load = 1'b1; rows_in = 8'hA5; push_exp(8'hA5);
    step();
    load = 1'b0; rows_in = 8'h3C;
    chk_st("a5_first", st(1, 1, 4'd4, 0, 0));
    chk_addr("a5_first", 3'd0, 3'd7);
    step(); step(); step();
    chk_st("a5_last", st(1, 1, 4'd1, 0, 0));
    chk_addr("a5_last", 3'd7, 3'd0);
    step();
    chk_st("a5_done", st(0, 0, 4'd0, 1, 0));
    chk_addr("a5_hold", 3'd7, 3'd0);
    step();
    chk_st("a5_idle", st(0, 0, 4'd0, 0, 0));
    chk_empty("a5");

    // Single top row with a three-cycle stall.
    out_ready = 1'b0;
    load = 1'b1; rows_in = 8'h80; push_exp(8'h80);
    step();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_st("stall", st(1, 1, 4'd1, 0, 0));
      chk_addr("stall", 3'd7, 3'd7);
      step();
    end
    out_ready = 1'b1;
    step();
    chk_st("stall_done", st(0, 0, 4'd0, 1, 0));
    chk_addr("stall_hold", 3'd7, 3'd7);
    step();
    chk_st("stall_idle", st(0, 0, 4'd0, 0, 0));
    chk_empty("stall");

    // Empty vector: only a done pulse.
    load = 1'b1; rows_in = 8'h00;
    step();
    load = 1'b0;
    chk_st("zero_done", st(0, 0, 4'd0, 1, 0));
    step();
    chk_st("zero_idle", st(0, 0, 4'd0, 0, 0));

    // Full vector with loads during the scan, including on the final handshake.
    load = 1'b1; rows_in = 8'hFF; push_exp(8'hFF);
    step();
    load = 1'b0;
    step(); step();
    load = 1'b1; rows_in = 8'h0F;
    step();
    load = 1'b0;
    chk_st("ff_err1", st(1, 1, 4'd5, 0, 1));
    chk_addr("ff_err1", 3'd3, 3'd4);
    step();
    chk_st("ff_after_err1", st(1, 1, 4'd4, 0, 0));
    step(); step(); step();
    chk_st("ff_last", st(1, 1, 4'd1, 0, 0));
    chk_addr("ff_last", 3'd7, 3'd0);
    load = 1'b1;
    step();
    load = 1'b0;
    chk_st("ff_err2_done", st(0, 0, 4'd0, 1, 1));
    step();
    chk_st("ff_idle", st(0, 0, 4'd0, 0, 0));
    chk_empty("ff");

    // Asynchronous reset after two of five handshakes.
    load = 1'b1; rows_in = 8'h1F; push_exp(8'h1F);
    step();
    load = 1'b0;
    step(); step();
    chk_st("rst_pre", st(1, 1, 4'd3, 0, 0));
    chk_addr("rst_pre", 3'd2, 3'd2);
    rst_n = 1'b0;
    #1;
    chk_st("rst_mid", st(0, 0, 4'd0, 0, 0));
    chk_addr("rst_mid", 3'd0, 3'd0);
    q0.delete(); q1.delete();
    step();
    rst_n = 1'b1;
    step();
    chk_st("rst_nodone", st(0, 0, 4'd0, 0, 0));
    load = 1'b1; rows_in = 8'h01; push_exp(8'h01);
    step();
    load = 1'b0;
    chk_st("post_rst_first", st(1, 1, 4'd1, 0, 0));
    chk_addr("post_rst_first", 3'd0, 3'd0);
    step();
    chk_st("post_rst_done", st(0, 0, 4'd0, 1, 0));
    chk_empty("post_rst");
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
